// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter in front of the mux stage.
//
// Arbitrates N = 2**SELECT_SIZE valid/ready requesters onto one valid/ready
// output channel and drives the mux select (`port`). While a transfer is
// backpressured, the grant stays locked so the select holds still. Priority
// rotates to the index after the granted one on every accepted transfer.
// Outputs are combinational from the state and the inputs, so a request
// appears on out_valid in the same cycle it is raised.
//
// Optional feature (macro RR_ARB_BURST_EN): adds the req_last/out_last ports.
// A grant then covers a whole burst. The lock is taken on the first beat and
// is released only by a handshake on a beat with last set.
//
// Ports:
//   clk        system clock; all state updates on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  [N] per-requester valid
//   req_ready  [N] per-requester ready; at most one bit set
//   out_valid  output channel valid
//   out_ready  downstream ready
//   port       [SELECT_SIZE] index of the granted requester (mux select)
//   grant      [N] one-hot of port, qualified by out_valid
//   req_last   [N] per-requester last-beat flag (RR_ARB_BURST_EN only)
//   out_last   last flag of the granted requester (RR_ARB_BURST_EN only)

module rr_arbiter #(
  parameter int unsigned SELECT_SIZE = 2,
  localparam int unsigned N = 2 ** SELECT_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req_valid,
  output logic [N-1:0]           req_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SELECT_SIZE-1:0] port,
`ifdef RR_ARB_BURST_EN
  input  logic [N-1:0]           req_last,
  output logic                   out_last,
`endif
  output logic [N-1:0]           grant
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t                 state;
  logic [SELECT_SIZE-1:0] ptr;
  logic [SELECT_SIZE-1:0] held_port;

  logic [2*N-1:0]         req_dbl;
  logic [N-1:0]           req_rot;
  logic [SELECT_SIZE-1:0] win_offset;
  logic [SELECT_SIZE-1:0] winner;
  logic                   any_req;

  logic [SELECT_SIZE-1:0] sel;
  logic                   valid;
  logic                   handshake;
  logic                   beat_last;

  // Rotate requests so that index ptr lands at bit 0; the lowest set bit of
  // the rotated vector is then the round-robin winner relative to ptr.
  always_comb begin
    req_dbl    = {req_valid, req_valid};
    req_rot    = N'(req_dbl >> ptr);
    any_req    = |req_rot;
    win_offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        win_offset = SELECT_SIZE'(i);
      end
    end
    // Offset addition wraps modulo N because N is a power of two.
    winner = any_req ? (ptr + win_offset) : '0;
  end

  // Select and channel outputs; reset forces everything idle.
  always_comb begin
    sel   = '0;
    valid = 1'b0;
    if (!rst) begin
      if (state == LOCKED) begin
        sel   = held_port;
        valid = req_valid[held_port];
      end else begin
        sel   = winner;
        valid = any_req;
      end
    end

    handshake = valid & out_ready;
    port      = sel;
    out_valid = valid;
    grant     = valid ? (N'(1) << sel) : '0;
    req_ready = handshake ? (N'(1) << sel) : '0;

`ifdef RR_ARB_BURST_EN
    beat_last = req_last[sel];
    out_last  = valid & req_last[sel];
`else
    // Without bursts every accepted beat closes the grant.
    beat_last = 1'b1;
`endif
  end

  // Lock / priority state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOCKED;
      ptr       <= '0;
      held_port <= '0;
    end else begin
      case (state)
        UNLOCKED: begin
          if (valid) begin
            if (handshake && beat_last) begin
              ptr <= sel + SELECT_SIZE'(1);
            end else begin
              // Backpressured, or first beat of an unfinished burst.
              state     <= LOCKED;
              held_port <= sel;
            end
          end
        end
        LOCKED: begin
          if (handshake && beat_last) begin
            ptr   <= sel + SELECT_SIZE'(1);
            state <= UNLOCKED;
          end
`ifndef RR_ARB_BURST_EN
          // Requester withdrew valid while holding the grant: drop the lock
          // and keep priority where it was.
          else if (!valid) begin
            state <= UNLOCKED;
          end
`endif
        end
        default: state <= UNLOCKED;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter: directed steps from the test plan,
// then randomized traffic checked against a behavioural reference model.
module tb_rr_arbiter;

  localparam int unsigned SS = 2;
  localparam int unsigned N  = 2 ** SS;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic          out_ready;
  logic [SS-1:0] port;
  logic [N-1:0]  grant;
  logic [N-1:0]  req_last;
  logic          out_last;

  int compared;
  int mismatched;

  // Reference model state
  bit m_locked;
  int m_ptr;
  int m_held;

  // Reference model outputs for the current cycle
  bit           e_valid;
  int           e_port;
  logic [N-1:0] e_grant;
  logic [N-1:0] e_ready;
  bit           e_last;

  rr_arbiter #(.SELECT_SIZE(SS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .port      (port),
`ifdef RR_ARB_BURST_EN
    .req_last  (req_last),
    .out_last  (out_last),
`endif
    .grant     (grant)
  );

`ifndef RR_ARB_BURST_EN
  assign out_last = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit burst_mode();
`ifdef RR_ARB_BURST_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Expected outputs from the arbitration rules.
  task automatic model_eval();
    e_valid = 1'b0;
    e_port  = 0;
    if (!rst) begin
      if (m_locked) begin
        e_port  = m_held;
        e_valid = req_valid[m_held];
      end else begin
        for (int i = 0; i < int'(N); i++) begin
          int k;
          k = (m_ptr + i) % int'(N);
          if (!e_valid && req_valid[k]) begin
            e_valid = 1'b1;
            e_port  = k;
          end
        end
      end
    end
    e_grant = '0;
    if (e_valid) e_grant[e_port] = 1'b1;
    e_ready = (e_valid && out_ready) ? e_grant : '0;
    e_last  = burst_mode() ? (e_valid && req_last[e_port]) : 1'b0;
  endtask

  // Advance the model by one clock edge.
  task automatic model_step();
    bit hs;
    bit last;
    hs   = e_valid && out_ready;
    last = burst_mode() ? req_last[e_port] : 1'b1;
    if (rst) begin
      m_locked = 1'b0;
      m_ptr    = 0;
      m_held   = 0;
    end else if (m_locked && !e_valid) begin
      if (!burst_mode()) m_locked = 1'b0;
    end else if (e_valid) begin
      if (hs && last) begin
        m_ptr    = (e_port + 1) % int'(N);
        m_locked = 1'b0;
      end else begin
        m_locked = 1'b1;
        m_held   = e_port;
      end
    end
  endtask

  task automatic check(input string tag, input int exp_port);
    model_eval();
    compared++;
    assert (out_valid === e_valid) else begin
      mismatched++;
      $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, e_valid);
    end
    compared++;
    assert (port === SS'(e_port)) else begin
      mismatched++;
      $error("FAIL %s port got %0d exp %0d", tag, port, e_port);
    end
    compared++;
    assert (grant === e_grant) else begin
      mismatched++;
      $error("FAIL %s grant got %b exp %b", tag, grant, e_grant);
    end
    compared++;
    assert (req_ready === e_ready) else begin
      mismatched++;
      $error("FAIL %s req_ready got %b exp %b", tag, req_ready, e_ready);
    end
    if (burst_mode()) begin
      compared++;
      assert (out_last === e_last) else begin
        mismatched++;
        $error("FAIL %s out_last got %0b exp %0b", tag, out_last, e_last);
      end
    end
    // Directed plan value, independent of the model.
    if (exp_port >= 0) begin
      compared++;
      assert (port === SS'(exp_port)) else begin
        mismatched++;
        $error("FAIL %s plan_port got %0d exp %0d", tag, port, exp_port);
      end
    end
  endtask

  // Apply inputs for one cycle, check mid-cycle, then clock.
  task automatic cyc(input logic r, input logic [N-1:0] v, input logic rdy,
                     input logic [N-1:0] lst, input string tag, input int exp_port);
    rst       = r;
    req_valid = v;
    out_ready = rdy;
    req_last  = lst;
    @(negedge clk);
    check(tag, exp_port);
    model_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_locked   = 1'b0;
    m_ptr      = 0;
    m_held     = 0;
    rst        = 1'b1;
    req_valid  = '0;
    out_ready  = 1'b0;
    req_last   = '1;
    @(posedge clk);
    #1;

    // 1. Reset forces idle outputs; first cycle after release grants 0.
    cyc(1'b1, 4'b1111, 1'b1, 4'b1111, "t1_rst", 0);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t1_rel", 0);

    // 2. Fairness with everyone requesting.
    cyc(1'b1, 4'b0000, 1'b0, 4'b1111, "t2_rst", 0);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t2_c0", 0);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t2_c1", 1);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t2_c2", 2);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t2_c3", 3);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t2_c4", 0);

    // 3. Backpressure lock holds the select.
    cyc(1'b1, 4'b0000, 1'b0, 4'b1111, "t3_rst", 0);
    cyc(1'b0, 4'b0010, 1'b0, 4'b1111, "t3_c0", 1);
    cyc(1'b0, 4'b0011, 1'b0, 4'b1111, "t3_c1", 1);
    cyc(1'b0, 4'b0011, 1'b1, 4'b1111, "t3_c2", 1);
    cyc(1'b0, 4'b0001, 1'b1, 4'b1111, "t3_c3", 0);

    // 4. Pointer wrap.
    cyc(1'b1, 4'b0000, 1'b0, 4'b1111, "t4_rst", 0);
    cyc(1'b0, 4'b0100, 1'b1, 4'b1111, "t4_hs2", 2);
    cyc(1'b0, 4'b0101, 1'b1, 4'b1111, "t4_wrap", 0);
    cyc(1'b0, 4'b0101, 1'b1, 4'b1111, "t4_next", 2);

    // 5. Reset in the middle of a lock.
    cyc(1'b1, 4'b0000, 1'b0, 4'b1111, "t5_rst", 0);
    cyc(1'b0, 4'b0100, 1'b0, 4'b1111, "t5_lock", 2);
    cyc(1'b1, 4'b0100, 1'b0, 4'b1111, "t5_midrst", 0);
    cyc(1'b0, 4'b1111, 1'b1, 4'b1111, "t5_after", 0);

    // 6. Burst grant with a valid gap (only meaningful with bursts enabled).
    if (burst_mode()) begin
      cyc(1'b1, 4'b0000, 1'b0, 4'b1111, "t6_rst", 0);
      cyc(1'b0, 4'b0001, 1'b1, 4'b0001, "t6_pre", 0);
      cyc(1'b0, 4'b0011, 1'b1, 4'b0000, "t6_b1", 1);
      cyc(1'b0, 4'b0001, 1'b1, 4'b0000, "t6_gap", 1);
      cyc(1'b0, 4'b0011, 1'b1, 4'b0000, "t6_b2", 1);
      cyc(1'b0, 4'b0011, 1'b1, 4'b0010, "t6_b3", 1);
      cyc(1'b0, 4'b0001, 1'b1, 4'b1111, "t6_post", 0);
    end

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      logic          r;
      logic [N-1:0]  v;
      logic          rdy;
      logic [N-1:0]  lst;
      r   = ($urandom_range(0, 63) == 0);
      v   = N'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      lst = N'($urandom);
      cyc(r, v, rdy, lst, "rand", -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
